// File: rtl/subtractor_32bit_serial.sv
// ---------------------------------------------------------------------------
// subtractor_32bit_serial
//   Slice-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, computed one
//   SLICE-bit slice per clock, LSB slice first. A single slice subtractor is
//   reused for every slice; the borrow ripples between slices through br_q.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands a/b valid          in_ready   high only in IDLE
//   a, b       minuend / subtrahend (WIDTH bits, unsigned)
//   out_valid  diff/borrow/zero valid      out_ready  consumer accepts result
//   diff       (a - b) mod 2^WIDTH
//   borrow     1 iff a < b
//   zero       1 iff diff == 0
// ---------------------------------------------------------------------------
module subtractor_32bit_serial #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] LAST = KW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e             state_q;
   logic [KW-1:0]      k_q;
   logic               br_q;
   logic [WIDTH-1:0]   a_q, b_q, diff_q, diff_d;
   logic               borrow_q, zero_q;
   logic [SLICE-1:0]   a_s, b_s;
   logic [SLICE:0]     sub_d;
   logic               bo_d;

   // One shared slice subtractor; the extra MSB of the (SLICE+1)-bit result
   // goes to 1 exactly when a_s - b_s - br is negative.
   always_comb begin
      a_s    = a_q[int'(k_q)*SLICE +: SLICE];
      b_s    = b_q[int'(k_q)*SLICE +: SLICE];
      sub_d  = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, br_q};
      bo_d   = sub_d[SLICE];
      diff_d = diff_q;
      diff_d[int'(k_q)*SLICE +: SLICE] = sub_d[SLICE-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         k_q      <= '0;
         br_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  br_q    <= 1'b0;
                  k_q     <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               diff_q <= diff_d;
               br_q   <= bo_d;
               if (k_q == LAST) begin
                  // Final slice: publish borrow/zero from the completed word.
                  borrow_q <= bo_d;
                  zero_q   <= (diff_d == '0);
                  state_q  <= DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Handshake flags decode from state only: no input-to-output paths.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_subtractor_32bit_serial.sv
module tb_subtractor_32bit_serial;

   typedef struct packed {
      logic [31:0] d;
      logic        bo;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, borrow, zero;
   logic [31:0] a, b, diff;

   exp_t        sb[$];
   exp_t        e;
   int          tests = 0;
   int          fails = 0;
   int          lat, seen;

   subtractor_32bit_serial #(.WIDTH(32), .SLICE(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow(borrow), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Present operands, push the model result, complete the input handshake.
   // Returns at accept edge + 1.
   task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input int gap);
      int n = 0;
      exp_t x;
      repeat (gap) @(posedge clk);
      #1;
      a = ta; b = tb_; in_valid = 1'b1;
      x.d = ta - tb_; x.bo = (ta < tb_); x.z = ((ta - tb_) == 32'd0);
      sb.push_back(x);
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("in_ready_timeout", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges until out_valid; optionally scramble operands while busy.
   task automatic wait_valid(input bit scramble, output int l);
      l = 0;
      while (!out_valid && l < 50) begin
         if (scramble) begin a = $urandom; b = $urandom; end
         @(posedge clk); #1; l++;
      end
      chk("out_valid_timeout", 32'(l < 50), 32'd1);
   endtask

   task automatic take(input int hold);
      exp_t x;
      repeat (hold) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(negedge clk);
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         x = sb.pop_front();
         chk("diff", diff, x.d);
         chk("borrow", 32'(borrow), 32'(x.bo));
         chk("zero", 32'(zero), 32'(x.z));
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_xfer_out_valid", 32'(out_valid), 32'd0);
      chk("post_xfer_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", diff, 32'd0);
      rst = 1'b0;

      // Leave a nonzero result behind, then reset mid-cycle.
      send(32'h0000_0005, 32'h0000_0007, 0);
      wait_valid(1'b0, lat);
      take(0);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_diff", diff, 32'd0);
      chk("arst_borrow", 32'(borrow), 32'd0);
      chk("arst_zero", 32'(zero), 32'd0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (10) begin @(negedge clk); if (out_valid) seen++; end
      chk("idle_no_valid", seen, 0);

      // Basic subtraction, latency, borrow crossing slices.
      out_ready = 1'b0;
      send(32'h1234_5678, 32'h0000_0079, 0);
      wait_valid(1'b0, lat);
      chk("latency", lat, 4);
      take(0);
      send(32'h0001_0000, 32'h0000_0001, 0); wait_valid(1'b0, lat); take(0);

      // Underflow and zero.
      send(32'h0000_0000, 32'h0000_0001, 1); wait_valid(1'b0, lat); take(0);
      send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 0); wait_valid(1'b0, lat); take(0);
      send(32'h0000_0000, 32'hFFFF_FFFF, 0); wait_valid(1'b0, lat); take(0);

      // Backpressure: result stable, new in_valid ignored.
      send(32'h8000_0000, 32'h0000_0003, 0);
      wait_valid(1'b0, lat);
      e = sb[0];
      repeat (7) begin
         in_valid = 1'b1; a = $urandom; b = $urandom;
         @(negedge clk);
         chk("bp_diff", diff, e.d);
         chk("bp_borrow", 32'(borrow), 32'(e.bo));
         chk("bp_zero", 32'(zero), 32'(e.z));
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      take(0);
      seen = 0;
      repeat (6) begin @(negedge clk); if (out_valid) seen++; end
      chk("bp_ignored_op", seen, 0);

      // Operand changes during BUSY have no effect.
      send(32'hCAFE_0100, 32'h0BAD_F00D, 0);
      wait_valid(1'b1, lat);
      take(2);

      // Reset during the second BUSY cycle aborts the operation.
      send(32'd1000, 32'd1, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      void'(sb.pop_back());
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (8) begin @(negedge clk); if (out_valid) seen++; end
      chk("abort_no_valid", seen, 0);
      send(32'd100, 32'd58, 0); wait_valid(1'b0, lat); take(0);

      // Random stream with gaps on both sides.
      for (int i = 0; i < 20; i++) begin
         send($urandom, $urandom, int'($urandom_range(0, 3)));
         wait_valid(1'b0, lat);
         take(int'($urandom_range(0, 3)));
      end
      chk("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/subtractor_32bit_serial.md
Name: subtractor_32bit_serial

Overview:
- Byte-serial unsigned subtractor; the inverse-operation companion to the hierarchical adder datapath.
- Computes a - b over WIDTH bits, one SLICE-bit slice per clock, LSB slice first, with the borrow rippling between slices through a register.
- Valid/ready handshake on input and output.
- Used where area matters more than throughput: one slice subtractor is reused for every slice of the operand.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a positive multiple of SLICE.
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff, borrow and zero are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow  output  1  1 iff a < b (unsigned).
- zero  output  1  1 iff diff == 0.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; slice index = 0; borrow register = 0; operand and diff registers = 0.
  - in_ready = 1, out_valid = 0, diff = 0, borrow = 0, zero = 0.
- State machine, three states:
  - IDLE:
    - in_ready = 1, out_valid = 0.
    - On in_valid && in_ready at a rising edge: latch a and b, clear the borrow register, set the slice index to 0, go to BUSY.
  - BUSY:
    - in_ready = 0, out_valid = 0.
    - Each edge computes {bo, d} = a[k] - b[k] - br, with (SLICE+1)-bit arithmetic. k is the slice index, br is the borrow register, and bo is 1 when the true result is negative.
    - Writes d into diff slice k and bo into br, then increments k.
    - When k == NSLICE-1 at the edge, goes to DONE instead of incrementing.
  - DONE:
    - out_valid = 1.
    - borrow = final br; zero = (diff == 0).
    - diff, borrow and zero are stable while out_valid && !out_ready.
    - On out_ready at an edge, goes to IDLE. out_valid drops and in_ready rises in the same cycle.
- Latency and throughput:
  - Accept at edge t0; out_valid is high after edge t0+NSLICE (4 edges for the defaults).
  - One operation per NSLICE+2 cycles at best.
  - A new operation cannot be accepted in the same cycle a result is consumed.
- Operand handling:
  - a and b are sampled only at the accept edge.
  - Input changes during BUSY or DONE have no effect.
  - in_valid asserted outside IDLE is ignored. The producer holds in_valid until it sees in_ready.
- Outputs and wrap-around:
  - diff, borrow and zero hold their last values in IDLE until the next operation writes them. Only out_valid qualifies them.
  - During BUSY, diff is partially updated and must not be consumed.
  - Wrap-around: the result is modulo 2^WIDTH with no saturation, e.g. 0 - 1 = 0xFFFFFFFF with borrow = 1.
- Reset mid-operation: an asynchronous rst during BUSY or DONE aborts the operation. No out_valid is produced for the aborted operands.
- out_ready asserted outside DONE has no effect.
- The design is fully synchronous apart from rst. There are no combinational paths from inputs to outputs: in_ready and out_valid decode from the state only.

Test Plan:
1. Reset then idle: assert rst asynchronously mid-cycle -> in_ready=1, out_valid=0, diff=0, borrow=0 immediately. Hold in_valid=0 for 10 cycles -> no out_valid.
2. Basic subtraction with slice-crossing borrows:
   - a=0x12345678, b=0x00000079, out_ready=1 -> out_valid exactly 4 cycles after accept, diff=0x123455FF, borrow=0, zero=0.
   - a=0x00010000, b=0x00000001 -> diff=0x0000FFFF. This checks the borrow crossing two slices.
3. Underflow and zero:
   - a=0, b=1 -> diff=0xFFFFFFFF, borrow=1, zero=0.
   - a=b=0xDEADBEEF -> diff=0, borrow=0, zero=1.
   - a=0x00000000, b=0xFFFFFFFF -> diff=0x00000001, borrow=1.
4. Output backpressure: hold out_ready=0 for 7 cycles after out_valid -> diff, borrow and zero unchanged, in_ready stays 0, and a new in_valid with different operands is ignored. Release out_ready -> one transfer, then in_ready=1 the next cycle.
5. Operand stability: change a and b every cycle during BUSY -> result matches the operands latched at the accept edge.
6. Reset mid-operation and back-to-back:
   - Assert rst at the second BUSY cycle -> IDLE immediately, with no out_valid. The next operation, a=100, b=58, gives diff=42.
   - Stream 20 random operand pairs with random in_valid/out_ready gaps -> every result matches the reference model (a-b) mod 2^32 and borrow = (a<b), in order.
